// File: rtl/gmr_keystream_ctrl.sv
// Sequencer for the gmr keystream generator: loads seeds, discards warm-up bits, packs bytes into a 2-entry FIFO.
// Define GMR_CTRL_ZERO_SEED_CHK_EN to reject starts whose LFSR-M or LFSR-L seed is zero.
module gmr_keystream_ctrl #(
   parameter int LOAD_CYCLES = 2,
   parameter int WARMUP      = 32,
   parameter int CNT_W       = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [6:0]       i_seed_lfsrM,
   input  logic [12:0]      i_seed_lfsrL,
   input  logic [CNT_W-1:0] i_nbytes,
   output logic             o_gmr_rst,
   output logic [6:0]       o_gmr_seed_lfsrM,
   output logic [12:0]      o_gmr_seed_lfsrL,
   input  logic             i_gmr_keystream,
   output logic [7:0]       o_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_overrun
);

   localparam int LW = $clog2(LOAD_CYCLES) + 1;
   localparam int WW = $clog2(WARMUP) + 1;
   localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_CYCLES - 1);
   localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP - 1);

   typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_WARMUP, ST_RUN, ST_DRAIN, ST_DONE} state_t;

   state_t           state_q, state_d;
   logic [LW-1:0]    loadCnt_q, loadCnt_d;
   logic [WW-1:0]    warmCnt_q, warmCnt_d;
   logic [2:0]       bitCnt_q, bitCnt_d;
   logic [7:0]       shift_q, shift_d;
   logic [CNT_W-1:0] bytesLeft_q, bytesLeft_d;
   logic [6:0]       seedM_q, seedM_d;
   logic [12:0]      seedL_q, seedL_d;
   logic [7:0]       head_q, head_d, tail_q, tail_d;
   logic [1:0]       fifoCnt_q, fifoCnt_d;
   logic             valid_q, valid_d, gmrRst_q, gmrRst_d, busy_q, busy_d;
   logic             done_q, done_d, overrun_q, overrun_d;
   logic             abortNow, byteDone, pop, accept, seedBad;
   logic [7:0]       newByte;

`ifdef GMR_CTRL_ZERO_SEED_CHK_EN
   assign seedBad = (i_seed_lfsrM == 7'd0) || (i_seed_lfsrL == 13'd0);
`else
   assign seedBad = 1'b0;
`endif

   // Head and tail are explicit registers so o_data comes straight from a flop.
   always_comb begin
      state_d     = state_q;
      loadCnt_d   = loadCnt_q;
      warmCnt_d   = warmCnt_q;
      bitCnt_d    = bitCnt_q;
      shift_d     = shift_q;
      bytesLeft_d = bytesLeft_q;
      seedM_d     = seedM_q;
      seedL_d     = seedL_q;
      overrun_d   = overrun_q;
      head_d      = head_q;
      tail_d      = tail_q;
      fifoCnt_d   = fifoCnt_q;

      abortNow = i_abort && (state_q != ST_IDLE);
      newByte  = {shift_q[6:0], i_gmr_keystream};
      byteDone = (state_q == ST_RUN) && (bitCnt_q == 3'd7);
      pop      = valid_q && i_ready;
      accept   = byteDone && !abortNow && ((fifoCnt_q != 2'd2) || pop);

      unique case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               if (seedBad) begin
                  overrun_d = 1'b1;
               end else begin
                  seedM_d     = i_seed_lfsrM;
                  seedL_d     = i_seed_lfsrL;
                  bytesLeft_d = i_nbytes;
                  overrun_d   = 1'b0;
                  loadCnt_d   = '0;
                  warmCnt_d   = '0;
                  bitCnt_d    = '0;
                  state_d     = (i_nbytes == '0) ? ST_DONE : ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            if (loadCnt_q == LOAD_LAST) state_d = ST_WARMUP;
            else                        loadCnt_d = loadCnt_q + LW'(1);
         end
         ST_WARMUP: begin
            if (warmCnt_q == WARM_LAST) state_d = ST_RUN;
            else                        warmCnt_d = warmCnt_q + WW'(1);
         end
         ST_RUN: begin
            shift_d  = newByte;
            bitCnt_d = bitCnt_q + 3'd1;
            if (byteDone) begin
               if (bytesLeft_q != '0) bytesLeft_d = bytesLeft_q - CNT_W'(1);
               if (bytesLeft_q <= CNT_W'(1)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((fifoCnt_q == 2'd0) || ((fifoCnt_q == 2'd1) && pop)) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (abortNow) begin
         state_d   = ST_IDLE;
         fifoCnt_d = 2'd0;
      end else begin
         unique case ({pop, accept})
            2'b10: begin
               head_d    = tail_q;
               fifoCnt_d = fifoCnt_q - 2'd1;
            end
            2'b01: begin
               if (fifoCnt_q == 2'd0) head_d = newByte;
               else                   tail_d = newByte;
               fifoCnt_d = fifoCnt_q + 2'd1;
            end
            2'b11: begin
               if (fifoCnt_q == 2'd1) begin
                  head_d = newByte;
               end else begin
                  head_d = tail_q;
                  tail_d = newByte;
               end
            end
            default: ;
         endcase
         if (byteDone && !accept) overrun_d = 1'b1;
      end

      valid_d  = (fifoCnt_d != 2'd0);
      gmrRst_d = !((state_d == ST_WARMUP) || (state_d == ST_RUN));
      done_d   = (state_q == ST_DONE) && !abortNow;
      busy_d   = (state_d != ST_IDLE) || done_d;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         loadCnt_q   <= '0;
         warmCnt_q   <= '0;
         bitCnt_q    <= '0;
         shift_q     <= '0;
         bytesLeft_q <= '0;
         seedM_q     <= '0;
         seedL_q     <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         fifoCnt_q   <= '0;
         valid_q     <= 1'b0;
         gmrRst_q    <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         loadCnt_q   <= loadCnt_d;
         warmCnt_q   <= warmCnt_d;
         bitCnt_q    <= bitCnt_d;
         shift_q     <= shift_d;
         bytesLeft_q <= bytesLeft_d;
         seedM_q     <= seedM_d;
         seedL_q     <= seedL_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         fifoCnt_q   <= fifoCnt_d;
         valid_q     <= valid_d;
         gmrRst_q    <= gmrRst_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         overrun_q   <= overrun_d;
      end
   end

   assign o_gmr_rst        = gmrRst_q;
   assign o_gmr_seed_lfsrM = seedM_q;
   assign o_gmr_seed_lfsrL = seedL_q;
   assign o_data           = head_q;
   assign o_valid          = valid_q;
   assign o_busy           = busy_q;
   assign o_done           = done_q;
   assign o_overrun        = overrun_q;

endmodule

// File: tb/tb_gmr_keystream_ctrl.sv
// Directed self-checking bench for gmr_keystream_ctrl; a small stand-in for gmr replays a fixed 64-bit keystream.
module tb_gmr_keystream_ctrl;

   logic        i_clk, i_rst, i_start, i_abort, i_ready, i_gmr_keystream;
   logic [6:0]  i_seed_lfsrM;
   logic [12:0] i_seed_lfsrL;
   logic [15:0] i_nbytes;
   logic        o_gmr_rst, o_valid, o_busy, o_done, o_overrun;
   logic [6:0]  o_gmr_seed_lfsrM;
   logic [12:0] o_gmr_seed_lfsrL;
   logic [7:0]  o_data;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   // Keystream bits 0..31 (DEADBEEF) are warm-up; packed bytes are A5, C3, 3C, 96.
   logic [63:0] ksPattern = 64'hDEAD_BEEF_A5C3_3C96;
   logic [5:0]  ksIdx;
   logic [7:0]  gotBytes [8];

   gmr_keystream_ctrl #(.LOAD_CYCLES(2), .WARMUP(32), .CNT_W(16)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
      .i_seed_lfsrM(i_seed_lfsrM), .i_seed_lfsrL(i_seed_lfsrL), .i_nbytes(i_nbytes),
      .o_gmr_rst(o_gmr_rst), .o_gmr_seed_lfsrM(o_gmr_seed_lfsrM), .o_gmr_seed_lfsrL(o_gmr_seed_lfsrL),
      .i_gmr_keystream(i_gmr_keystream), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
      .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // The stand-in generator restarts from bit 0 whenever it is held in reset.
   always @(posedge i_clk) begin
      if (o_gmr_rst) ksIdx <= 6'd0;
      else           ksIdx <= ksIdx + 6'd1;
   end
   assign i_gmr_keystream = ksPattern[~ksIdx];

   task automatic stepCycle();
      @(posedge i_clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic start, input logic [6:0] m, input logic [12:0] l,
                                input logic [15:0] n);
      i_start      = start;
      i_seed_lfsrM = m;
      i_seed_lfsrL = l;
      i_nbytes     = n;
   endtask

   task automatic startRun(input logic [6:0] m, input logic [12:0] l, input logic [15:0] n);
      applyStimulus(1'b1, m, l, n);
      stepCycle();
      i_start = 1'b0;
   endtask

   task automatic collectRun(input int maxCycles, output int nGot, output int nDone);
      nGot  = 0;
      nDone = 0;
      for (int c = 0; c < maxCycles; c++) begin
         if (o_valid && i_ready) begin
            if (nGot < 8) gotBytes[nGot] = o_data;
            nGot++;
         end
         stepCycle();
         if (o_done) nDone++;
         if (!o_busy && !o_done) break;
      end
   endtask

   int nGot, nDone, lat, firstLow;

   initial begin
      i_rst   = 1'b1;
      i_abort = 1'b0;
      i_ready = 1'b1;
      applyStimulus(1'b0, 7'd0, 13'd0, 16'd0);
      $display("[TB] reset values");
      stepCycle();
      stepCycle();
      checkOutput("rst_gmr_rst", o_gmr_rst, 1);
      checkOutput("rst_seedM", o_gmr_seed_lfsrM, 0);
      checkOutput("rst_seedL", o_gmr_seed_lfsrL, 0);
      checkOutput("rst_data", o_data, 0);
      checkOutput("rst_valid", o_valid, 0);
      checkOutput("rst_busy", o_busy, 0);
      checkOutput("rst_done", o_done, 0);
      checkOutput("rst_overrun", o_overrun, 0);
      i_rst = 1'b0;
      stepCycle();

      $display("[TB] normal run, 4 bytes");
      startRun(7'b1011010, 13'b1010110100111, 16'd4);
      checkOutput("norm_busy", o_busy, 1);
      checkOutput("norm_gmr_rst_e1", o_gmr_rst, 1);
      checkOutput("norm_seedM", o_gmr_seed_lfsrM, 32'h5A);
      checkOutput("norm_seedL", o_gmr_seed_lfsrL, 32'h15A7);
      lat = 0;
      firstLow = 0;
      for (int c = 1; c <= 60; c++) begin
         stepCycle();
         if (firstLow == 0 && !o_gmr_rst) firstLow = c;
         if (o_valid) begin
            lat = c;
            break;
         end
      end
      checkOutput("norm_gmr_rst_release", firstLow, 2);
      checkOutput("norm_first_valid_latency", lat, 42);
      collectRun(200, nGot, nDone);
      checkOutput("norm_nbytes", nGot, 4);
      checkOutput("norm_byte0", gotBytes[0], 8'hA5);
      checkOutput("norm_byte1", gotBytes[1], 8'hC3);
      checkOutput("norm_byte2", gotBytes[2], 8'h3C);
      checkOutput("norm_byte3", gotBytes[3], 8'h96);
      checkOutput("norm_done_pulses", nDone, 1);
      checkOutput("norm_overrun", o_overrun, 0);
      checkOutput("norm_idle", o_busy, 0);

      $display("[TB] backpressure, 5 bytes");
      i_ready = 1'b0;
      startRun(7'b1011010, 13'b1010110100111, 16'd5);
      nDone = 0;
      for (int c = 0; c < 80; c++) begin
         stepCycle();
         if (o_done) nDone++;
      end
      checkOutput("bp_overrun", o_overrun, 1);
      checkOutput("bp_valid_held", o_valid, 1);
      checkOutput("bp_head", o_data, 8'hA5);
      checkOutput("bp_still_busy", o_busy, 1);
      checkOutput("bp_no_early_done", nDone, 0);
      i_ready = 1'b1;
      collectRun(50, nGot, nDone);
      checkOutput("bp_nbytes", nGot, 2);
      checkOutput("bp_byte0", gotBytes[0], 8'hA5);
      checkOutput("bp_byte1", gotBytes[1], 8'hC3);
      checkOutput("bp_done_pulses", nDone, 1);
      checkOutput("bp_idle", o_busy, 0);

      $display("[TB] zero count clears overrun");
      startRun(7'd3, 13'd5, 16'd0);
      checkOutput("zero_overrun_cleared", o_overrun, 0);
      checkOutput("zero_busy", o_busy, 1);
      checkOutput("zero_done_e1", o_done, 0);
      stepCycle();
      checkOutput("zero_done_e2", o_done, 1);
      checkOutput("zero_valid", o_valid, 0);
      stepCycle();
      checkOutput("zero_done_end", o_done, 0);
      checkOutput("zero_busy_end", o_busy, 0);

      $display("[TB] start ignored during RUN");
      startRun(7'd1, 13'd1, 16'd2);
      for (int c = 0; c < 38; c++) stepCycle();
      applyStimulus(1'b1, 7'd9, 13'd9, 16'd9);
      stepCycle();
      i_start = 1'b0;
      collectRun(200, nGot, nDone);
      checkOutput("ign_nbytes", nGot, 2);
      checkOutput("ign_byte1", gotBytes[1], 8'hC3);
      checkOutput("ign_seedM_kept", o_gmr_seed_lfsrM, 1);
      checkOutput("ign_done_pulses", nDone, 1);

      $display("[TB] abort in WARMUP");
      startRun(7'd2, 13'd2, 16'd4);
      for (int c = 0; c < 10; c++) stepCycle();
      i_abort = 1'b1;
      stepCycle();
      i_abort = 1'b0;
      checkOutput("abw_busy", o_busy, 0);
      checkOutput("abw_gmr_rst", o_gmr_rst, 1);
      checkOutput("abw_valid", o_valid, 0);
      nDone = 0;
      for (int c = 0; c < 50; c++) begin
         stepCycle();
         if (o_done || o_valid) nDone++;
      end
      checkOutput("abw_no_done_no_valid", nDone, 0);

      $display("[TB] abort in RUN with one byte buffered");
      i_ready = 1'b0;
      startRun(7'd2, 13'd2, 16'd3);
      for (int c = 0; c < 60; c++) begin
         stepCycle();
         if (o_valid) break;
      end
      stepCycle();
      stepCycle();
      checkOutput("abr_buffered", o_valid, 1);
      i_abort = 1'b1;
      stepCycle();
      i_abort = 1'b0;
      checkOutput("abr_valid", o_valid, 0);
      checkOutput("abr_busy", o_busy, 0);
      checkOutput("abr_done", o_done, 0);
      checkOutput("abr_gmr_rst", o_gmr_rst, 1);
      nDone = 0;
      for (int c = 0; c < 10; c++) begin
         stepCycle();
         if (o_done) nDone++;
      end
      checkOutput("abr_no_done", nDone, 0);
      i_ready = 1'b1;

      $display("[TB] zero LFSR-L seed");
      startRun(7'b1011010, 13'd0, 16'd1);
`ifdef GMR_CTRL_ZERO_SEED_CHK_EN
      checkOutput("zs_busy", o_busy, 0);
      checkOutput("zs_overrun", o_overrun, 1);
      checkOutput("zs_seedL_kept", o_gmr_seed_lfsrL, 2);
`else
      collectRun(200, nGot, nDone);
      checkOutput("zs_nbytes", nGot, 1);
      checkOutput("zs_byte0", gotBytes[0], 8'hA5);
      checkOutput("zs_done_pulses", nDone, 1);
      checkOutput("zs_overrun", o_overrun, 0);
`endif

      $display("[TB] asynchronous reset mid-run");
      i_ready = 1'b0;
      startRun(7'd5, 13'd6, 16'd4);
      for (int c = 0; c < 45; c++) stepCycle();
      checkOutput("amr_pre_valid", o_valid, 1);
      #2;
      i_rst = 1'b1;
      #1;
      checkOutput("amr_gmr_rst", o_gmr_rst, 1);
      checkOutput("amr_valid", o_valid, 0);
      checkOutput("amr_busy", o_busy, 0);
      checkOutput("amr_data", o_data, 0);
      checkOutput("amr_seedM", o_gmr_seed_lfsrM, 0);
      checkOutput("amr_seedL", o_gmr_seed_lfsrL, 0);
      checkOutput("amr_overrun", o_overrun, 0);
      stepCycle();
      i_rst = 1'b0;
      stepCycle();

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/gmr_keystream_ctrl.md
# gmr_keystream_ctrl

Sequencer for the `gmr` Massey-Rueppel keystream generator.
- On a start request it captures the two LFSR seeds and holds `gmr` in reset long enough to load them.
- It then discards a warm-up run of keystream bits, packs the following bits MSB-first into bytes, and delivers a requested number of bytes over a valid/ready interface through a 2-entry buffer.
- It sits between the cipher's host-side control logic and the `gmr` instance, and is the only driver of `gmr`'s reset and seed inputs.

## Interface
Parameters:
- `LOAD_CYCLES`, 2: cycles `o_gmr_rst` is held high in LOAD (≥1).
- `WARMUP`, 32: keystream bits discarded before packing (≥1).
- `CNT_W`, 16: width of the byte-count request.

Ports:
- `i_clk` in 1: the single clock; all logic is on its rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_start` in 1: start request, sampled only in IDLE.
- `i_abort` in 1: abort the current run from any non-IDLE state.
- `i_seed_lfsrM` in 7: LFSR-M seed, captured when a start is accepted.
- `i_seed_lfsrL` in 13: LFSR-L seed, captured when a start is accepted.
- `i_nbytes` in `CNT_W`: number of bytes to produce, captured when a start is accepted.
- `o_gmr_rst` out 1: reset/load strobe to `gmr`.
- `o_gmr_seed_lfsrM` out 7: registered seed to `gmr`.
- `o_gmr_seed_lfsrL` out 13: registered seed to `gmr`.
- `i_gmr_keystream` in 1: `gmr` keystream bit.
- `o_data` out 8: head byte of the buffer.
- `o_valid` out 1: buffer not empty.
- `i_ready` in 1: consumer accepts `o_data` when `o_valid && i_ready`.
- `o_busy` out 1: state ≠ IDLE.
- `o_done` out 1: one-cycle pulse on normal completion.
- `o_overrun` out 1: sticky; a byte was dropped. Cleared on the next accepted start.

## Operation
States:
- **IDLE:** `o_gmr_rst`=1. On `i_start`=1:
  - capture the seeds and `i_nbytes`;
  - clear `o_overrun`;
  - go to LOAD. If the captured count is 0, go straight to DONE instead.
  - `i_start` in any other state is ignored.
- **LOAD:** `o_gmr_rst`=1 for exactly `LOAD_CYCLES` cycles, then go to WARMUP.
- **WARMUP:** `o_gmr_rst`=0. Sample one `i_gmr_keystream` bit per cycle and discard it. After `WARMUP` bits, go to RUN.
- **RUN:** sample one bit per cycle into an 8-bit shift register; the first bit sampled is `o_data[7]`.
  - Each 8th bit completes a byte. The byte is pushed to the buffer and the bytes-remaining count is decremented.
  - When the count reaches 0, go to DRAIN.
- **DRAIN:** `o_gmr_rst`=1, which freezes `gmr`. Wait until the buffer is empty, then go to DONE.
- **DONE:** `o_done`=1 for one cycle, then go to IDLE.

Buffer: 2-entry FIFO.
- Push when a byte completes; pop on `o_valid && i_ready`.
- If the FIFO is full when a byte completes and there is no pop that cycle:
  - the byte is dropped and `o_overrun` is set;
  - the byte still decrements the count.
- A push and a pop in the same cycle on a full FIFO is a legal push.

Abort: `i_abort`=1 in any non-IDLE state forces IDLE on the next edge.
- The FIFO is flushed (`o_valid`=0) and `o_gmr_rst`=1.
- No `o_done` pulse is produced. `o_overrun` is retained.
- If `i_abort` and a byte completion occur on the same edge, abort wins and the byte is discarded.

Width rules:
- The bytes-remaining counter is `CNT_W` bits and never wraps.
- The warm-up and load counters are sized with `$clog2` of their parameter plus 1.

## Timing
- Reset values:
  - `o_gmr_rst`=1;
  - both seed outputs 0;
  - `o_data`=0, `o_valid`=0, `o_busy`=0, `o_done`=0, `o_overrun`=0;
  - state IDLE, FIFO empty.
- Asserting `i_rst` mid-run behaves like reset at any time: the state returns immediately to these values.
- All outputs are registered.
- For a start sampled at edge E0:
  - `o_busy` rises after E0;
  - `o_gmr_rst` stays 1 through edge E0+`LOAD_CYCLES`;
  - the first keystream bit is sampled at edge E0+`LOAD_CYCLES`+1;
  - the first `o_valid` rises after edge E0+`LOAD_CYCLES`+`WARMUP`+8, i.e. a start-to-first-byte latency of `LOAD_CYCLES`+`WARMUP`+8 cycles.
- Throughput is 1 byte per 8 cycles in RUN; the keystream is never stalled.
- `o_done` asserts the cycle after the last pop empties the FIFO.
- `o_busy` falls together with the `o_done` pulse ending.

## Configuration
- `GMR_CTRL_ZERO_SEED_CHK_EN` defined: a start with `i_seed_lfsrM`==0 or `i_seed_lfsrL`==0 is rejected.
  - The block stays in IDLE; no seeds or count are captured.
  - `o_overrun` is set, serving as the error flag.
- Not defined: any seed is accepted and no check logic is synthesised.

## Test plan
- Reset mid-run: assert `i_rst` during RUN → all outputs return to reset values asynchronously; `o_gmr_rst`=1.
- Normal run: `i_seed_lfsrM`=7'b1011010, `i_seed_lfsrL`=13'b1010110100111, `i_nbytes`=4, `i_ready`=1 → 4 bytes equal the golden `gmr` model's bits 32..63 packed MSB-first. First `o_valid` appears 42 cycles after start; `o_done` pulses once; `o_overrun`=0.
- Backpressure: `i_nbytes`=5, `i_ready`=0 until all bytes are produced → bytes 0–1 are held; bytes 2–4 are dropped; `o_overrun`=1; after `i_ready`=1, 2 bytes are delivered, then `o_done`.
- Zero count and ignored start: `i_nbytes`=0 → `o_done` pulses 2 cycles after start and `o_valid` never rises. A second `i_start` during RUN has no effect.
- Abort: `i_abort` pulse in WARMUP and, separately, in RUN with 1 byte buffered → IDLE on the next cycle; `o_valid`=0; no `o_done`.
- Macro: with `GMR_CTRL_ZERO_SEED_CHK_EN` defined, `i_seed_lfsrL`=0 → `o_busy` stays 0 and `o_overrun`=1. Without the macro, the same stimulus runs to `o_done`.
